// File: rtl/painter_pkg.sv
`default_nettype none
// ============================================================================
// Module : painter_pkg
// Brief  : Shared types for the POV painter. paint_state_t is also used by the
//          image-buffer controller, so the encoding is pinned explicitly.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package painter_pkg;

  localparam logic [1:0] PS_IDLE  = 2'd0;
  localparam logic [1:0] PS_ARMED = 2'd1;
  localparam logic [1:0] PS_PAINT = 2'd2;
  localparam logic [1:0] PS_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = PS_IDLE,
    ARMED = PS_ARMED,
    PAINT = PS_PAINT,
    DRAIN = PS_DRAIN
  } paint_state_t;

endpackage
`default_nettype wire

// File: rtl/column_tick_counter.sv
`default_nettype none
// ============================================================================
// Module : column_tick_counter
// Brief  : Counts forward encoder steps between column requests. Reverse
//          steps walk the count back, saturating at zero.
// Ports  : clk, reset     - clock, synchronous active-high reset
//          clear_i        - force the count to zero
//          step_i         - a step to be counted this cycle
//          fwd_i          - step is in the painting direction
//          col_due_o      - combinational pulse: this step completes a column
// Rev    : 1.0 - initial release
// ============================================================================
module column_tick_counter #(
  parameter int TICKS_PER_COL = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic step_i,
  input  logic fwd_i,
  output logic col_due_o
);

  localparam int CNT_W = $clog2(TICKS_PER_COL);
  localparam logic [CNT_W:0] LAST_CNT = (CNT_W + 1)'(TICKS_PER_COL - 1);

  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    col_due_o  = 1'b0;
    if (clear_i) begin
      tick_cnt_d = '0;
    end else if (step_i) begin
      if (fwd_i) begin
        // tick_cnt + 1 == TICKS_PER_COL, compared one bit wider to avoid wrap
        if ({1'b0, tick_cnt_q} == LAST_CNT) begin
          tick_cnt_d = '0;
          col_due_o  = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end else if (tick_cnt_q != '0) begin
        tick_cnt_d = tick_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/painter_column_scheduler.sv
`default_nettype none
// ============================================================================
// Module : painter_column_scheduler
// Brief  : Turns encoder steps into LED column requests. Once armed, one
//          column is requested every TICKS_PER_COL forward steps; columns the
//          driver cannot take in time are skipped and flagged as overrun.
// Ports  : clk, reset           - clock, synchronous active-high reset
//          step_valid_i/dir_i   - decoded quadrature step and its direction
//          arm_i, abort_i       - start an image / return to idle
//          col_valid_o/index_o  - column request, held until col_ready_i
//          col_ready_i          - driver accepts the pending request
//          paint_dir_o          - direction latched on the first step
//          busy_o, overrun_o    - not idle / sticky skipped-column flag
//          done_o               - one-cycle pulse at image completion
// Rev    : 1.0 - initial release
// ============================================================================
module painter_column_scheduler
  import painter_pkg::*;
#(
  parameter int TICKS_PER_COL = 16,
  parameter int NUM_COLS      = 64,
  parameter int COL_W         = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_valid_i,
  input  logic             step_dir_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             col_ready_i,
  output logic             col_valid_o,
  output logic [COL_W-1:0] col_index_o,
  output logic             paint_dir_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             done_o
);

  localparam logic [COL_W-1:0] LAST_IDX = COL_W'(NUM_COLS - 1);

  paint_state_t     state_q, state_d;
  logic [COL_W-1:0] next_idx_q, next_idx_d;
  logic [COL_W-1:0] col_index_q, col_index_d;
  logic             col_valid_q, col_valid_d;
  logic             paint_dir_q, paint_dir_d;
  logic             overrun_q, overrun_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             cnt_clear;
  logic             cnt_step;
  logic             cnt_due;
  logic             col_due;
  logic             slot_free;

  // Counter restarts on arm and again on the first step, which itself
  // produces column 0 rather than being counted.
  assign cnt_clear = !abort_i &&
                     ((state_q == IDLE && arm_i) || (state_q == ARMED && step_valid_i));
  assign cnt_step  = !abort_i && state_q == PAINT && step_valid_i;

  column_tick_counter #(
    .TICKS_PER_COL(TICKS_PER_COL)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .step_i   (cnt_step),
    .fwd_i    (step_dir_i == paint_dir_q),
    .col_due_o(cnt_due)
  );

  assign col_due   = (state_q == ARMED && step_valid_i) || (state_q == PAINT && cnt_due);
  assign slot_free = !col_valid_q || col_ready_i;

  always_comb begin
    state_d     = state_q;
    next_idx_d  = next_idx_q;
    col_index_d = col_index_q;
    col_valid_d = col_valid_q;
    paint_dir_d = paint_dir_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;

    if (col_valid_q && col_ready_i) begin
      col_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d    = ARMED;
          next_idx_d = '0;
          overrun_d  = 1'b0;
        end
      end
      ARMED: begin
        if (step_valid_i) begin
          paint_dir_d = step_dir_i;
          state_d     = PAINT;
        end
      end
      PAINT: begin
      end
      DRAIN: begin
        // Final request accepted (or nothing left pending): image complete
        if (slot_free) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A due column always advances next_idx so the image stays locked to
    // position; it is only loaded if the single request slot is free.
    if (col_due) begin
      if (slot_free) begin
        col_valid_d = 1'b1;
        col_index_d = next_idx_q;
      end else begin
        overrun_d = 1'b1;
      end
      next_idx_d = next_idx_q + 1'b1;
      if (next_idx_q == LAST_IDX) begin
        state_d = DRAIN;
      end
    end

    if (abort_i) begin
      state_d     = IDLE;
      col_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      next_idx_q  <= '0;
      col_index_q <= '0;
      col_valid_q <= 1'b0;
      paint_dir_q <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_idx_q  <= next_idx_d;
      col_index_q <= col_index_d;
      col_valid_q <= col_valid_d;
      paint_dir_q <= paint_dir_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign col_valid_o = col_valid_q;
  assign col_index_o = col_index_q;
  assign paint_dir_o = paint_dir_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: doc/painter_column_scheduler.md
# painter_column_scheduler

Sequences LED column output from encoder motion. It consumes single-cycle step events from the quadrature decoder. Once armed, it issues one column request to the LED strip driver every `TICKS_PER_COL` steps in the painting direction. It flags overruns when the driver cannot keep up, and signals completion after `NUM_COLS` columns. It sits between the encoder decoder and the column fetch/shift-out datapath.

## Interface
- `TICKS_PER_COL`, default 16: forward encoder steps between column requests; must be ≥2.
- `NUM_COLS`, default 64: columns per image; must be ≥1.
- `COL_W`, default 6: column index width; must satisfy 2^COL_W ≥ NUM_COLS.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `step_valid` in 1: one-cycle pulse per decoded quadrature edge.
- `step_dir` in 1: direction of the step, valid with `step_valid`.
- `arm` in 1: pulse; start a new image (honoured only in IDLE).
- `abort` in 1: pulse; return to IDLE from any state.
- `col_valid` out 1: column request pending.
- `col_index` out COL_W: column to display; stable while `col_valid`.
- `col_ready` in 1: driver accepts the request when `col_valid` and `col_ready` are both high.
- `paint_dir` out 1: latched painting direction.
- `busy` out 1: state ≠ IDLE.
- `overrun` out 1: sticky; at least one column was skipped.
- `done` out 1: one-cycle pulse when the image completes.

## Operation
- States (`paint_state_t`):
  - IDLE → ARMED on `arm`.
  - ARMED → PAINT on first `step_valid`.
  - PAINT → DRAIN when the last column is issued or skipped.
  - DRAIN → IDLE when the request handshake completes; `done` pulses that cycle.
  - `abort` forces IDLE in any state and has priority over all other events.
- On `arm` in IDLE: clear `tick_cnt`, `next_idx`, `overrun`.
- First step in ARMED:
  - `paint_dir` <= `step_dir`.
  - Column 0 becomes due immediately.
  - `next_idx` <= 1 and `tick_cnt` <= 0.
- PAINT, step with `step_dir == paint_dir`:
  - If `tick_cnt + 1 == TICKS_PER_COL`: `tick_cnt` <= 0 and a column is due.
  - Otherwise `tick_cnt` increments.
- PAINT, step opposite to `paint_dir`: `tick_cnt` decrements, saturating at 0. Columns are never un-issued.
- Due column handling:
  - The request slot is free when `!col_valid || col_ready`.
  - Free slot: `col_valid` <= 1 and `col_index` <= current `next_idx`.
  - Slot not free: `overrun` <= 1 and the column is skipped.
  - `next_idx` increments in both cases, so image geometry stays locked to position.
- After column `NUM_COLS-1` is due (issued or skipped) → DRAIN. Steps are ignored in DRAIN.
- DRAIN with no pending request: `done` the next cycle.
- `col_valid` drops after a handshake unless a new column is loaded in the same cycle.
- `abort` or `reset`: `col_valid` <= 0 immediately. Withdrawing a request is permitted only here.
- Reset values: `col_valid`=0, `col_index`=0, `paint_dir`=0, `busy`=0, `overrun`=0, `done`=0; state IDLE; `tick_cnt`=0, `next_idx`=0.
- Steps in IDLE are ignored. `arm` outside IDLE is ignored.

## Timing
- All outputs are registered.
- Step at cycle N that makes a column due → `col_valid`/`col_index` updated at N+1.
- A handshake at cycle N and a new due column at N coexist: the new request is visible at N+1 with no overrun.
- `done` is high exactly one cycle: either N+1 after the final handshake at N, or after entering DRAIN with no pending request. `busy` falls in the same cycle `done` rises.
- `arm` at N → ARMED at N+1; a step at N+1 is honoured.
- At most one step per cycle is assumed from the decoder.

## Structure
- `painter_pkg`: `paint_state_t` enum (IDLE, ARMED, PAINT, DRAIN), shared with the future image-buffer controller.
- Sub-module `column_tick_counter`:
  - Inputs: step, dir match, clear.
  - Output: `col_due` pulse.
  - Holds the `tick_cnt` saturating up/down logic.
- FSM, request slot and overrun logic live in the top module.

## Test plan
- Arm; 1 step dir=1; 16×15 further dir=1 steps with `col_ready`=1 → 16 requests, indices 0..15, each 1 cycle after its due step, `paint_dir`=1, `overrun`=0.
- Arm; steps +10, −4, +10 → column 1 due on the final +10 step (count 10→6→16); `tick_cnt` saturates at 0 when reverse steps exceed forward ones.
- Hold `col_ready`=0 through two due columns → index 0 pending, column 1 skipped, `overrun`=1 and sticky. Next grant and due column gives index 2. `overrun` clears only on the next `arm`.
- `NUM_COLS`=4, `col_ready`=1, 49 forward steps → indices 0..3. Hold `col_ready` low for 3 cycles after the last request, then grant → `done` pulses 1 cycle after the grant and `busy`=0.
- `abort` mid-PAINT with `col_valid`=1 → next cycle `col_valid`=0 and state IDLE. Steps ignored until `arm`.
- `reset` asserted during DRAIN, and simultaneous `arm`+`abort` in IDLE → all outputs at reset values, state IDLE.
